// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-read-port MIPS register file.
//   DATA_W_DEFAULT / ADDR_W_DEFAULT : default register width and index width
//   ZERO_IDX                        : index of the optional hardwired-zero entry
//   get_field()                     : extracts field k of width w from a flattened bus
package mips_rf_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int ZERO_IDX       = 0;

  // Flattened buses are zero-extended to FIELD_BUS_W before slicing.
  // Callers truncate the FIELD_W-bit result to the width they need.
  localparam int FIELD_BUS_W = 512;
  localparam int FIELD_W     = 128;

  function automatic logic [FIELD_W-1:0] get_field(input logic [FIELD_BUS_W-1:0] bus,
                                                   input int unsigned           k,
                                                   input int unsigned           w);
    logic [FIELD_BUS_W-1:0] shifted;
    shifted = bus >> (k * w);
    return shifted[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus between the pipeline and the register file.
//   master : decode/writeback side; drives write, read and reserve requests
//   slave  : register file; returns read data, per-port pending and pending_any
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     write;
  logic [ADDR_W-1:0]        write_reg;
  logic [DATA_W-1:0]        write_data;
  logic [NUM_RD*ADDR_W-1:0] read_reg;
  logic [NUM_RD*DATA_W-1:0] read_data;
  logic [NUM_RD-1:0]        read_pending;
  logic                     reserve;
  logic [ADDR_W-1:0]        reserve_reg;
  logic                     pending_any;

  modport master (
    output write, write_reg, write_data, read_reg, reserve, reserve_reg,
    input  read_data, read_pending, pending_any
  );

  modport slave (
    input  write, write_reg, write_data, read_reg, reserve, reserve_reg,
    output read_data, read_pending, pending_any
  );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register pending scoreboard for RAW hazard detection.
//   clk, rst        : clock, synchronous active-high reset
//   reserve/_reg    : set the bit of a register whose result is in flight
//   clear/_reg      : clear the bit of the register being written back
//   lookup_reg      : flattened per-port indices (port k at [k*ADDR_W +: ADDR_W])
//   lookup_pending  : registered scoreboard bit for each lookup port
//   pending_any     : OR of all scoreboard bits
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reserve,
  input  logic [ADDR_W-1:0]        reserve_reg,
  input  logic                     clear,
  input  logic [ADDR_W-1:0]        clear_reg,
  input  logic [NUM_RD*ADDR_W-1:0] lookup_reg,
  output logic [NUM_RD-1:0]        lookup_pending,
  output logic                     pending_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DEPTH-1:0] bits;
  logic             reserve_ok;

  // The hardwired-zero entry never becomes pending.
  assign reserve_ok = reserve && !(ZERO_REG && reserve_reg == ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      bits <= '0;
    end else begin
      // NOTE: both updates are non-blocking to the same vector; the later
      // statement wins on a shared index, so a new reservation overrides the
      // clear from a simultaneous writeback.
      if (clear)      bits[clear_reg]   <= 1'b0;
      if (reserve_ok) bits[reserve_reg] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    logic [ADDR_W-1:0] idx;
    assign idx               = ADDR_W'(get_field(FIELD_BUS_W'(lookup_reg), k, ADDR_W));
    assign lookup_pending[k] = bits[idx];
  end

  assign pending_any = |bits;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file for the MIPS datapath.
//   cclk : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset; clears data and scoreboard
//   bus  : register_file_mp_if slave port
//          write/write_reg/write_data : writeback port
//          read_reg/read_data         : NUM_RD combinational read ports
//          read_pending/pending_any   : scoreboard status
//          reserve/reserve_reg        : mark a result as in flight
module register_file_mp
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic              cclk,
  input logic              rst,
  register_file_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              write_ok;
  logic [NUM_RD-1:0] sb_pending;

  // Writes to the hardwired-zero entry are dropped entirely.
  assign write_ok = bus.write && !(ZERO_REG && bus.write_reg == ZERO_ADDR);

  // NOTE: the array is reset because a reset must leave every entry reading
  // 0; this builds the file from flops rather than a RAM macro.
  always_ff @(posedge cclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_ok) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk            (cclk),
    .rst            (rst),
    .reserve        (bus.reserve),
    .reserve_reg    (bus.reserve_reg),
    .clear          (bus.write),
    .clear_reg      (bus.write_reg),
    .lookup_reg     (bus.read_reg),
    .lookup_pending (sb_pending),
    .pending_any    (bus.pending_any)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_read
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              is_zero;

    assign idx     = ADDR_W'(get_field(FIELD_BUS_W'(bus.read_reg), k, ADDR_W));
    // write_ok already excludes the zero entry, so hit never fires there.
    assign hit     = BYPASS && write_ok && (bus.write_reg == idx);
    assign is_zero = ZERO_REG && (idx == ZERO_ADDR);

    assign bus.read_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                               hit     ? bus.write_data :
                                                         regs[idx];
    // Data arriving this cycle on the bypass path is no longer a hazard.
    assign bus.read_pending[k] = sb_pending[k] & ~hit;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath; replaces the fixed 32x32, two-read-port register file.
- Adds:
  - a configurable number of read ports;
  - an optional hardwired-zero entry 0;
  - optional same-cycle write-to-read bypass;
  - a per-register pending scoreboard so the pipeline can detect RAW hazards on in-flight results.
- Sits between the decode stage (reads, reserve) and the writeback stage (write).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores write/reserve.
- BYPASS, 1, 1 = a read of the register being written this cycle returns write_data.

Ports:
- cclk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- write  in  1  write enable for write_reg/write_data.
- write_reg  in  ADDR_W  register index to write.
- write_data  in  DATA_W  data to write.
- read_reg  in  NUM_RD*ADDR_W  flattened read indices; port k at [k*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*DATA_W  flattened read data; port k at [k*DATA_W +: DATA_W].
- read_pending  out  NUM_RD  bit k = scoreboard bit of read_reg port k.
- reserve  in  1  mark reserve_reg as pending (result in flight).
- reserve_reg  in  ADDR_W  register index to reserve.
- pending_any  out  1  OR of all scoreboard bits.

Behaviour:
- Reset:
  - rst high at a rising edge clears all DEPTH entries to 0 and all scoreboard bits to 0.
  - write and reserve are ignored in that cycle.
  - Outputs after reset: read_data all 0, read_pending 0, pending_any 0.
- Reads:
  - Combinational, zero latency.
  - read_data port k = regs[read_reg k], except for the bypass and zero-register cases below.
- Write:
  - write=1 at a rising edge loads regs[write_reg] <= write_data.
  - The new value is visible on read ports in the following cycle.
- Bypass (BYPASS=1):
  - Applies when write=1, write_reg == read_reg k, and the entry is not the zero entry.
  - read_data port k = write_data in the same cycle.
  - BYPASS=0: the old value is returned until the next cycle.
- Zero register (ZERO_REG=1):
  - Index 0 always reads 0 with read_pending 0.
  - Writes and reserves to 0 are dropped.
  - ZERO_REG=0: entry 0 behaves as an ordinary register.
- Scoreboard:
  - One bit per entry.
  - reserve=1 sets bit[reserve_reg] at the edge.
  - write=1 clears bit[write_reg] at the edge.
  - Clearing happens whether or not the bit was set.
  - read_pending k = bit[read_reg k] of the current state; it is not bypassed.
    - Exception: when BYPASS=1 and a write to that index occurs this cycle, read_pending k = 0, since data is available.
- Simultaneous events:
  - reserve and write to the same index in one cycle: data is written and the bit ends SET (new producer wins).
  - reserve of an already-pending index: bit stays set; no count is kept.
  - Two read ports at the same index return identical data and pending.
- Reset mid-operation: pending reservations are discarded; no residual state survives.
- pending_any is registered-state based: it reflects the scoreboard after the last edge.
- Widths: indices are unsigned. There are no out-of-range cases because DEPTH = 2**ADDR_W.

Decomposition:
- Shared package mips_rf_pkg:
  - default DATA_W/ADDR_W constants;
  - a ZERO_IDX constant;
  - a function for extracting field k from a flattened bus.
- Sub-module rf_scoreboard (DEPTH-bit set/clear vector with per-port lookup and pending_any).
  - The data array, bypass and zero logic stay in the top.

Test Plan:
- Reset, then read ports 0..1 at indices 0 and 31 -> read_data 0x00000000, read_pending 00, pending_any 0.
- Write reg 1 = 0x1, reg 2 = 0x2, reg 30 = 0xD, reg 31 = 0x15 over four edges; read ports at (30,31) -> 0xD, 0x15.
- Write of 0xFFFFFFFF to reg 0 with ZERO_REG=1 -> reg 0 reads 0.
  - Rerun with ZERO_REG=0 -> reads 0xFFFFFFFF.
- Bypass: write=1, write_reg=5, write_data=8, read port 0 at 5 in the same cycle -> 8 (BYPASS=1), or the previous value 0 (BYPASS=0).
- Scoreboard:
  - reserve reg 4 -> next cycle, read port 1 at 4 shows read_pending=1 and pending_any=1.
  - write reg 4 = 5 -> next cycle pending 0, data 5.
  - reserve and write reg 4 in the same cycle -> data updated, pending 1.
- Reserve regs 3 and 7, then assert rst for one edge -> all pending 0, all data 0; writes and reserves in the rst cycle have no effect.
- Run the NUM_RD=4 configuration with all four ports at distinct indices -> each returns its own value.
